// File: rtl/scan_ctrl_if.sv
// Bundle of scan enable (and optional blink request) inputs plus digit-drive outputs of scan_ctrl.
// blink_mask is present only when SCAN_CTRL_BLINK_EN is defined.
interface scan_ctrl_if;
   logic       en;
`ifdef SCAN_CTRL_BLINK_EN
   logic [7:0] blink_mask;
`endif
   logic [2:0] sel;
   logic [7:0] dig_n;
   logic       frame_tick;

`ifdef SCAN_CTRL_BLINK_EN
   modport master (output en, output blink_mask, input sel, input dig_n, input frame_tick);
   modport slave  (input en, input blink_mask, output sel, output dig_n, output frame_tick);
`else
   modport master (output en, input sel, input dig_n, input frame_tick);
   modport slave  (input en, output sel, output dig_n, output frame_tick);
`endif
endinterface

// File: rtl/scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with per-slot blanking and a frame pulse.
// Optional digit blink is built when SCAN_CTRL_BLINK_EN is defined.
module scan_ctrl #(
   parameter int DIV_CNT      = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int NUM_DIG      = 8,
   parameter int BLINK_FRAMES = 64
) (
   input logic        clk,
   input logic        rst,
   scan_ctrl_if.slave bus
);

   localparam int DW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
   localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(DIV_CNT - 1);
   localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYC);
   localparam logic [2:0]    SEL_LAST   = 3'(NUM_DIG - 1);

   if (DIV_CNT < 2 || BLANK_CYC < 0 || BLANK_CYC > DIV_CNT - 2 ||
       NUM_DIG < 1 || NUM_DIG > 8 || BLINK_FRAMES < 1) begin : g_param_check
      $error("scan_ctrl: illegal parameter set");
   end

   logic [DW-1:0] div_q, div_d;
   logic [2:0]    sel_q, sel_d;
   logic [BW-1:0] blank_q, blank_d;
   logic [7:0]    dig_q, dig_d;
   logic          ft_q, ft_d;
   logic [7:0]    lit;
   logic          frame_wrap;

`ifdef SCAN_CTRL_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frm_q, frm_d;
   logic          phase_q, phase_d;
`endif

   // Lit pattern for the current digit; blink forces it dark during the off phase.
   always_comb begin
      lit = ~(8'b1 << sel_q);
`ifdef SCAN_CTRL_BLINK_EN
      if (phase_q && bus.blink_mask[sel_q]) lit = 8'hFF;
`endif
   end

   always_comb begin
      div_d      = div_q;
      sel_d      = sel_q;
      blank_d    = blank_q;
      dig_d      = 8'hFF;
      ft_d       = 1'b0;
      frame_wrap = 1'b0;
      if (!bus.en) begin
         // Frozen scan: rearm the blank so resuming starts with a full guard.
         blank_d = BLANK_INIT;
      end else if (div_q == DIV_LAST) begin
         div_d      = '0;
         sel_d      = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
         blank_d    = BLANK_INIT;
         frame_wrap = (sel_q == SEL_LAST);
         ft_d       = frame_wrap;
      end else begin
         div_d = div_q + 1'b1;
         if (blank_q != '0) blank_d = blank_q - 1'b1;
         else               dig_d   = lit;
      end
   end

`ifdef SCAN_CTRL_BLINK_EN
   always_comb begin
      frm_d   = frm_q;
      phase_d = phase_q;
      if (frame_wrap) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         sel_q   <= 3'd0;
         blank_q <= BLANK_INIT;
         dig_q   <= 8'hFF;
         ft_q    <= 1'b0;
`ifdef SCAN_CTRL_BLINK_EN
         frm_q   <= '0;
         phase_q <= 1'b0;
`endif
      end else begin
         div_q   <= div_d;
         sel_q   <= sel_d;
         blank_q <= blank_d;
         dig_q   <= dig_d;
         ft_q    <= ft_d;
`ifdef SCAN_CTRL_BLINK_EN
         frm_q   <= frm_d;
         phase_q <= phase_d;
`endif
      end
   end

   assign bus.sel        = sel_q;
   assign bus.dig_n      = dig_q;
   assign bus.frame_tick = ft_q;

endmodule
